// File: rtl/cic_comp_fir.sv
// Decimating FIR compensator that sits behind the CIC decimator.
// One multiplier runs a sequential MAC over a circular sample buffer.
module cic_comp_fir #(
  parameter int BITS       = 16,
  parameter int TAPS       = 32,
  parameter int DECIM      = 2,
  parameter int COEFF_BITS = 18,
  parameter int ACC_BITS   = 40,
  parameter     COEFF_FILE = ""
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [BITS-1:0]         x_in,
  input  logic                    in_tick,
  input  logic                    coeff_we,
  input  logic [$clog2(TAPS)-1:0] coeff_addr,
  input  logic [COEFF_BITS-1:0]   coeff_data,
  output logic [BITS-1:0]         y_out,
  output logic                    out_tick,
  output logic                    busy,
  output logic                    overrun
);

  localparam int AW = $clog2(TAPS);
  localparam int CW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PB = BITS + COEFF_BITS;

  localparam logic [CW-1:0] TAPS_C  = CW'(TAPS);
  localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);

  localparam logic signed [ACC_BITS-1:0] RND =
    ACC_BITS'(1) <<< (COEFF_BITS - 2);
  localparam logic signed [ACC_BITS-1:0] SMAX =
    (ACC_BITS'(1) <<< (BITS - 1)) - 1;
  localparam logic signed [ACC_BITS-1:0] SMIN =
    -(ACC_BITS'(1) <<< (BITS - 1));
  localparam logic signed [BITS-1:0] YMAX = SMAX[BITS-1:0];
  localparam logic signed [BITS-1:0] YMIN = SMIN[BITS-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_ROUND,
    S_OUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0] phase;
  logic [AW-1:0] wptr;
  logic [AW-1:0] base;
  logic [AW-1:0] raddr;
  logic [CW-1:0] fill;
  logic [CW-1:0] fill_inc;
  logic [CW-1:0] fill_lat;
  logic [CW-1:0] cnt;
  logic          trig;
  logic          start;
  logic          vld_q;

  logic [BITS-1:0]       sbuf [TAPS];
  logic [COEFF_BITS-1:0] cmem [TAPS];

  logic signed [BITS-1:0]       samp_q;
  logic signed [BITS-1:0]       x_op;
  logic signed [COEFF_BITS-1:0] coef_q;
  logic signed [PB-1:0]         prod;
  logic signed [ACC_BITS-1:0]   acc;
  logic signed [ACC_BITS-1:0]   acc_rnd;
  logic signed [ACC_BITS-1:0]   acc_sh;
  logic signed [BITS-1:0]       y_sat;

  assign fill_inc = (fill == TAPS_C) ? fill : fill + 1'b1;
  assign trig     = in_tick && (phase == PH_LAST);
  assign start    = trig && (state == S_IDLE);
  assign raddr    = base - cnt[AW-1:0];
  assign x_op     = vld_q ? samp_q : '0;
  assign prod     = PB'(x_op) * PB'(coef_q);

  // History bookkeeping runs on every tick, whatever the MAC is doing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase   <= '0;
      wptr    <= '0;
      fill    <= '0;
      overrun <= 1'b0;
    end else begin
      if (in_tick) begin
        wptr  <= wptr + 1'b1;
        fill  <= fill_inc;
        phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      end
      if (trig && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (in_tick) begin
      sbuf[wptr] <= x_in;
    end
    if (coeff_we && !busy) begin
      cmem[coeff_addr] <= coeff_data;
    end
    samp_q <= sbuf[raddr];
    coef_q <= cmem[cnt[AW-1:0]];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_MAC;
      S_MAC:   if (cnt == TAPS_C) state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    out_tick = (state == S_OUT);
  end

  // cnt issues reads 0..TAPS-1; the product lands one cycle later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      base     <= '0;
      fill_lat <= '0;
      cnt      <= '0;
      acc      <= '0;
      vld_q    <= 1'b0;
      y_out    <= '0;
    end else begin
      vld_q <= (state == S_MAC) && (cnt < fill_lat);
      if (start) begin
        base     <= wptr;
        fill_lat <= fill_inc;
        cnt      <= '0;
        acc      <= '0;
      end
      if (state == S_MAC) begin
        cnt <= cnt + 1'b1;
        if (cnt != '0) begin
          acc <= acc + ACC_BITS'(prod);
        end
      end
      if (state == S_ROUND) begin
        y_out <= y_sat;
      end
    end
  end

  always_comb begin
    acc_rnd = acc + RND;
    acc_sh  = acc_rnd >>> (COEFF_BITS - 1);
    y_sat   = acc_sh[BITS-1:0];
    if (acc_sh > SMAX) begin
      y_sat = YMAX;
    end else if (acc_sh < SMIN) begin
      y_sat = YMIN;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir.
// Directed vectors; expected outputs and trigger cycles are queued.
module tb_cic_comp_fir;

  localparam int BITS = 16;
  localparam int TAPS = 32;
  localparam int DECIM = 2;
  localparam int CB = 18;
  localparam int AB = 40;
  localparam int LAT = TAPS + 3;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [BITS-1:0] x_in = '0;
  logic            in_tick = 1'b0;
  logic            coeff_we = 1'b0;
  logic [4:0]      coeff_addr = '0;
  logic [CB-1:0]   coeff_data = '0;
  logic [BITS-1:0] y_out;
  logic            out_tick;
  logic            busy;
  logic            overrun;

  typedef struct {
    int val;
    int trig;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  cic_comp_fir #(
    .BITS(BITS),
    .TAPS(TAPS),
    .DECIM(DECIM),
    .COEFF_BITS(CB),
    .ACC_BITS(AB),
    .COEFF_FILE("")
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .x_in(x_in),
    .in_tick(in_tick),
    .coeff_we(coeff_we),
    .coeff_addr(coeff_addr),
    .coeff_data(coeff_data),
    .y_out(y_out),
    .out_tick(out_tick),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  task automatic feed(input int x, input bit push,
                      input int expv, input int sp);
    @(posedge CLK); #1;
    x_in = BITS'(x);
    in_tick = 1'b1;
    if (push) sb.push_back('{val: expv, trig: cyc});
    @(posedge CLK); #1;
    in_tick = 1'b0;
    repeat (sp - 2) @(posedge CLK);
  endtask

  task automatic wr_coef(input int a, input int d);
    @(posedge CLK); #1;
    coeff_we = 1'b1;
    coeff_addr = 5'(a);
    coeff_data = CB'(d);
    @(posedge CLK); #1;
    coeff_we = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < TAPS; k++) wr_coef(k, v);
  endtask

  task automatic set_h0_only;
    wr_coef(0, 131071);
    for (int k = 1; k < TAPS; k++) wr_coef(k, 0);
  endtask

  task automatic do_reset;
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  initial begin : monitor
    int   brun;
    int   last_out;
    bit   prev_ot;
    exp_t e;
    brun = 0;
    last_out = -1;
    prev_ot = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        brun = 0;
        last_out = -1;
        prev_ot = 1'b0;
      end else begin
        if (busy) begin
          brun++;
        end else if (brun != 0) begin
          check("busy_len", brun, LAT);
          brun = 0;
        end
        if (out_tick) begin
          check("out_tick_width", prev_ot, 0);
          if (last_out >= 0)
            check("out_spacing", (cyc - last_out) >= LAT, 1);
          last_out = cyc;
          check("out_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("y_out", $signed(y_out), e.val);
            check("latency", cyc - e.trig, LAT);
          end
        end
        prev_ot = out_tick;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_y_out", y_out, 0);
    check("rst_out_tick", out_tick, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // Passthrough
    set_h0_only();
    feed(1000, 0, 0, 40);
    feed(2000, 1, 2000, 40);
    feed(3000, 0, 0, 40);
    feed(4000, 1, 4000, 40);

    // Impulse: outputs walk up the coefficient ramp
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(k, 1024 * (k + 1));
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 1)
        feed((i == 1) ? 32767 : 0, 1, 256 * i, 40);
      else
        feed(0, 0, 0, 40);
    end

    // Saturation at both rails, minimum tick spacing
    do_reset();
    set_all(131071);
    for (int i = 0; i < 32; i++)
      feed(32767, i % 2 == 1, 32767, TAPS + 4);
    do_reset();
    for (int i = 0; i < 32; i++)
      feed(-32768, i % 2 == 1, -32768, TAPS + 4);

    // Overrun, and a coefficient write while busy
    do_reset();
    set_h0_only();
    feed(100, 0, 0, 10);
    feed(200, 1, 200, 10);
    check("overrun_before", overrun, 0);
    feed(300, 0, 0, 2);
    check("busy_at_we", busy, 1);
    wr_coef(0, 0);
    repeat (6) @(posedge CLK);
    feed(400, 0, 0, 2);
    check("overrun_set", overrun, 1);
    check("busy_mid_mac", busy, 1);
    repeat (8) @(posedge CLK);
    feed(500, 0, 0, 10);
    feed(600, 1, 600, 10);
    feed(700, 0, 0, 10);
    feed(800, 0, 0, 10);
    repeat (40) @(posedge CLK);
    check("overrun_sticky", overrun, 1);

    // Reset in the middle of a MAC
    feed(900, 0, 0, 40);
    feed(1000, 0, 0, 2);
    repeat (9) @(posedge CLK);
    #1;
    check("busy_pre_rst", busy, 1);
    RST = 1'b1;
    #1;
    check("abort_out_tick", out_tick, 0);
    check("abort_busy", busy, 0);
    check("abort_overrun", overrun, 0);
    check("abort_y_out", y_out, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (50) @(posedge CLK);

    // Start-up fill: only post-reset samples contribute
    set_all(4096);
    for (int i = 0; i < 16; i++)
      feed(8192, i % 2 == 1, 512 * ((i + 1) / 2), 40);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge CLK);
    check("sb_drained", sb.size(), 0);
    repeat (5) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
